// File: rtl/borrow_skip_subtractor_seq.sv
// Multi-cycle subtractor: diff = a - b - bin, one BLOCK-bit block per clock, LSB block first.
// Borrow ripples inside a block; a skip path forwards the block's borrow-in when all bit pairs match.
module borrow_skip_subtractor_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4,
  localparam int unsigned NB   = WIDTH / BLOCK,
  localparam int unsigned SW   = $clog2(NB + 1),
  localparam int unsigned IW   = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf,
  output logic [SW-1:0]    skips
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic             br_q, br_d, bout_q, bout_d, zero_q, zero_d, ovf_q, ovf_d;
  logic [SW-1:0]    skips_q, skips_d;

  logic [31:0]      base;
  logic [BLOCK-1:0] blk_a, blk_b, blk_d;
  logic             ripple, blk_p, blk_bout;

  // Current block datapath
  always_comb begin
    base   = 32'(idx_q) * BLOCK;
    blk_a  = a_q[base +: BLOCK];
    blk_b  = b_q[base +: BLOCK];
    blk_d  = '0;
    ripple = br_q;
    for (int i = 0; i < int'(BLOCK); i++) begin
      blk_d[i] = blk_a[i] ^ blk_b[i] ^ ripple;
      ripple   = (~blk_a[i] & blk_b[i]) | (~(blk_a[i] ^ blk_b[i]) & ripple);
    end
    blk_p    = &(~(blk_a ^ blk_b));
    blk_bout = (blk_p & br_q) | ripple;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    skips_d = skips_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          diff_d  = '0;
          idx_d   = '0;
          skips_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        diff_d[base +: BLOCK] = blk_d;
        br_d = blk_bout;
        if (blk_p && br_q) skips_d = skips_q + SW'(1);
        if (idx_q == IW'(NB - 1)) begin
          bout_d  = blk_bout;
          zero_d  = ~|diff_d;
          ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ diff_d[WIDTH-1]);
          state_d = StDone;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      skips_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      skips_q <= skips_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign skips     = skips_q;

endmodule

// File: tb/tb_borrow_skip_subtractor_seq.sv
// Directed bench for borrow_skip_subtractor_seq with hand-computed expected results.
module tb_borrow_skip_subtractor_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] diff;
  logic        bout, zero, ovf;
  logic [2:0]  skips;

  int total = 0;
  int bad = 0;

  borrow_skip_subtractor_seq #(.WIDTH(16), .BLOCK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .bin(bin), .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .bout(bout),
    .zero(zero), .ovf(ovf), .skips(skips)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one accept edge.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic bi);
    a = av; b = bv; bin = bi; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; bin = ~bi;
  endtask

  // Edges counted from accept until out_valid, bounded at 20.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if ({diff, bout, zero, ovf, skips} !== 22'h0) begin
      bad++; $display("FAIL reset_outputs diff=%h bout=%b zero=%b ovf=%b skips=%0d exp all 0",
                      diff, bout, zero, ovf, skips);
    end
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int cyc;
    start_op(16'h1234, 16'h0234, 1'b0);
    wait_done(cyc);
    total++; if (cyc !== 4) begin bad++; $display("FAIL basic_latency got=%0d exp=4", cyc); end
    total++; if (diff !== 16'h1000) begin bad++; $display("FAIL basic_diff got=%h exp=1000", diff); end
    total++; if ({bout, zero, ovf} !== 3'b000) begin bad++; $display("FAIL basic_flags got=%b%b%b exp=000", bout, zero, ovf); end
    total++; if (skips !== 3'd0) begin bad++; $display("FAIL basic_skips got=%0d exp=0", skips); end
    consume();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL basic_consume in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_underflow();
    int cyc;
    start_op(16'h0000, 16'h0001, 1'b0);
    wait_done(cyc);
    total++; if (diff !== 16'hFFFF) begin bad++; $display("FAIL under_diff got=%h exp=ffff", diff); end
    total++; if ({bout, zero, ovf} !== 3'b100) begin bad++; $display("FAIL under_flags got=%b%b%b exp=100", bout, zero, ovf); end
    total++; if (skips !== 3'd3) begin bad++; $display("FAIL under_skips got=%0d exp=3", skips); end
    consume();
  endtask

  task automatic test_skip_chain();
    int cyc;
    start_op(16'hABCD, 16'hABCD, 1'b1);
    wait_done(cyc);
    total++; if (diff !== 16'hFFFF) begin bad++; $display("FAIL chain1_diff got=%h exp=ffff", diff); end
    total++; if ({bout, zero, ovf} !== 3'b100) begin bad++; $display("FAIL chain1_flags got=%b%b%b exp=100", bout, zero, ovf); end
    total++; if (skips !== 3'd4) begin bad++; $display("FAIL chain1_skips got=%0d exp=4", skips); end
    consume();
    start_op(16'hABCD, 16'hABCD, 1'b0);
    wait_done(cyc);
    total++; if (diff !== 16'h0000) begin bad++; $display("FAIL chain0_diff got=%h exp=0000", diff); end
    total++; if ({bout, zero, ovf} !== 3'b010) begin bad++; $display("FAIL chain0_flags got=%b%b%b exp=010", bout, zero, ovf); end
    total++; if (skips !== 3'd0) begin bad++; $display("FAIL chain0_skips got=%0d exp=0", skips); end
    consume();
  endtask

  task automatic test_overflow();
    int cyc;
    start_op(16'h8000, 16'h0001, 1'b0);
    wait_done(cyc);
    total++; if (diff !== 16'h7FFF) begin bad++; $display("FAIL ovf1_diff got=%h exp=7fff", diff); end
    total++; if ({bout, zero, ovf} !== 3'b001) begin bad++; $display("FAIL ovf1_flags got=%b%b%b exp=001", bout, zero, ovf); end
    total++; if (skips !== 3'd2) begin bad++; $display("FAIL ovf1_skips got=%0d exp=2", skips); end
    consume();
    start_op(16'h7FFF, 16'hFFFF, 1'b0);
    wait_done(cyc);
    total++; if (diff !== 16'h8000) begin bad++; $display("FAIL ovf2_diff got=%h exp=8000", diff); end
    total++; if ({bout, zero, ovf} !== 3'b101) begin bad++; $display("FAIL ovf2_flags got=%b%b%b exp=101", bout, zero, ovf); end
    consume();
  endtask

  task automatic test_back_to_back();
    int cyc;
    start_op(16'h0010, 16'h0001, 1'b0);
    wait_done(cyc);
    // Backpressure: hold the result while pushing ignored operands
    for (int i = 0; i < 3; i++) begin
      a = 16'h0F0F; b = 16'h1111; bin = 1'b1; in_valid = 1'b1;
      step();
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++; $display("FAIL hold_hs cyc=%0d out_valid=%b in_ready=%b exp 1/0", i, out_valid, in_ready);
      end
      total++; if (diff !== 16'h000F || {bout, zero, ovf} !== 3'b000 || skips !== 3'd0) begin
        bad++; $display("FAIL hold_stable cyc=%0d diff=%h flags=%b%b%b skips=%0d exp 000f/000/0",
                        i, diff, bout, zero, ovf, skips);
      end
    end
    in_valid = 1'b0;
    consume();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
    start_op(16'h0005, 16'h0003, 1'b1);
    wait_done(cyc);
    total++; if (cyc !== 4) begin bad++; $display("FAIL b2b_latency got=%0d exp=4", cyc); end
    total++; if (diff !== 16'h0001 || {bout, zero, ovf} !== 3'b000) begin
      bad++; $display("FAIL b2b_result diff=%h flags=%b%b%b exp 0001/000", diff, bout, zero, ovf);
    end
    consume();
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    start_op(16'h0000, 16'h0001, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_hs out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
    total++; if (diff !== 16'h0000) begin bad++; $display("FAIL midrst_diff got=%h exp=0000", diff); end
    step();
    #2 rst_n = 1'b1;
    step();
    start_op(16'h0010, 16'h0001, 1'b0);
    wait_done(cyc);
    total++; if (cyc !== 4) begin bad++; $display("FAIL fresh_latency got=%0d exp=4", cyc); end
    total++; if (diff !== 16'h000F || bout !== 1'b0) begin
      bad++; $display("FAIL fresh_result diff=%h bout=%b exp 000f/0", diff, bout);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_skip_chain();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/borrow_skip_subtractor_seq.md
# borrow_skip_subtractor_seq

Sequential multi-cycle subtractor computing `diff = a - b - bin` one BLOCK-bit block per clock, LSB block first. Inside each block the borrow ripples bit by bit. A borrow-skip path forwards the incoming borrow directly when every bit pair in the block is equal. It is the subtraction counterpart of the library's carry-skip adder, built for area-constrained datapaths that can accept WIDTH/BLOCK cycles of latency. Operands enter and results leave through valid/ready handshakes.

## Interface
- `WIDTH`, default 16: operand and result width; must be a multiple of BLOCK.
- `BLOCK`, default 4: bits processed per cycle.
- Derived `NB = WIDTH/BLOCK`, the number of blocks, which is also the number of compute cycles.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operands present.
- `in_ready`  output  1  block can accept operands.
- `a`  input  WIDTH  minuend.
- `b`  input  WIDTH  subtrahend.
- `bin`  input  1  borrow-in.
- `out_valid`  output  1  result available.
- `out_ready`  input  1  consumer accepts the result.
- `diff`  output  WIDTH  difference, `a - b - bin` mod 2^WIDTH.
- `bout`  output  1  final borrow-out; 1 means the unsigned result is negative.
- `zero`  output  1  `diff == 0`.
- `ovf`  output  1  signed two's-complement overflow.
- `skips`  output  $clog2(NB+1)  number of blocks in which the skip path carried the borrow.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE:** `in_ready=1`, `out_valid=0`. On `in_valid&&in_ready`:
  - latch `a`, `b`, `bin` into operand registers;
  - load `bin` into the borrow register;
  - clear `diff`, the block index `idx`, and `skips`;
  - move to RUN.
- **RUN:** `in_ready=0`. Each cycle processes block `idx`, with bits `[idx*BLOCK +: BLOCK]`:
  - per bit: `d = a^b^br`, `br_next = (~a&b) | (~(a^b)&br)`, rippled across the block;
  - block propagate `P` = AND over the block of `~(a^b)`;
  - borrow into the next block = `(P & br_in) | ripple_out`, which is numerically identical to pure ripple;
  - `skips` increments when `P && br_in`;
  - write `d` bits into `diff[idx*BLOCK +: BLOCK]` and update the borrow register.
- RUN exit: when `idx == NB-1`, move to DONE. Otherwise increment `idx`.
- Latched flags at the last block:
  - `bout` = final borrow;
  - `ovf = (a[W-1]^b[W-1]) & (a[W-1]^diff[W-1])`, evaluated on the final diff;
  - `zero` = reduction NOR of the final diff.
- **DONE:** `out_valid=1`, `in_ready=0`. All outputs hold stable until `out_valid&&out_ready`, then move to IDLE.
- No accept is possible in the DONE→IDLE cycle; `in_ready` rises only once in IDLE.
- `in_valid` outside IDLE is ignored. Operand inputs may change freely after acceptance.
- Reset value of every register is 0, so after reset:
  - state is IDLE, `in_ready=1`, `out_valid=0`;
  - `diff`, `bout`, `zero`, `ovf`, `skips` are all 0.
- Reset asserted mid-RUN or in DONE aborts immediately and the partial result is discarded. A new operation may be accepted on the first rising edge after `rst_n` deasserts.
- `diff`, `bout`, `zero`, `ovf`, `skips` are only meaningful while `out_valid=1`. `diff` may show partial values during RUN.

## Timing
- Accept at rising edge T0.
- Compute edges T1..TNB; the last one transitions the FSM to DONE. `out_valid=1` from edge TNB, giving a latency of NB cycles (4 for the defaults).
- Result consumed at the first edge with `out_ready=1` while in DONE. `in_ready=1` from the following cycle.
- Peak throughput is one operation per NB+2 cycles.
- All outputs are registered; there are no combinational paths from any input to any output.

## Test plan
1. **Basic subtraction, no borrow.** Reset, then `a=0x1234`, `b=0x0234`, `bin=0`.
   - Required: `diff=0x1000`, `bout=0`, `zero=0`, `ovf=0`.
   - `out_valid` rises exactly 4 cycles after accept.
2. **Underflow.** `a=0x0000`, `b=0x0001`, `bin=0`.
   - Required: `diff=0xFFFF`, `bout=1`, `ovf=0`.
   - `skips=3`: blocks 1–3 all have equal bit pairs with the borrow active.
3. **Full skip chain and zero result.** `a=b=0xABCD`.
   - With `bin=1`: required `diff=0xFFFF`, `bout=1`, `skips=4`.
   - With `bin=0`: required `diff=0x0000`, `zero=1`, `skips=0`.
4. **Signed overflow.**
   - `a=0x8000`, `b=0x0001`: required `diff=0x7FFF`, `ovf=1`, `bout=0`.
   - `a=0x7FFF`, `b=0xFFFF`: required `diff=0x8000`, `ovf=1`, `bout=1`.
5. **Handshake and backpressure.** Hold `out_ready=0` for 3 cycles in DONE.
   - Required: outputs stable, `in_ready=0`, and any `in_valid` pulses ignored.
   - Raise `out_ready`: the next cycle shows `in_ready=1`, and a back-to-back operation completes correctly.
6. **Reset mid-operation.** Assert `rst_n=0` during RUN at `idx=2`.
   - Required: `out_valid=0`, `in_ready=1`, `diff=0`.
   - A fresh operation `0x0010-0x0001` afterwards gives `diff=0x000F`, `bout=0`.
